// File: rtl/mc_dds_engine.sv
// Time-multiplexed multichannel DDS: one phase accumulator per channel, one channel
// issued per clock, shadowed register bank, LFM sweep, CFS hopping, shared LUT/scaler.
module mc_dds_engine #(
  parameter int NUM_CH  = 32,
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 16,
  parameter int LUT_AW  = 10,
  parameter int AMP_W   = 12,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8:0]              addr,
  input  logic [PHASE_W-1:0]      data,
  input  logic                    wr_en,
  input  logic                    sync,
  output logic signed [OUT_W-1:0] sine_out,
  output logic [CH_W-1:0]         current_channel,
  output logic                    channel_valid,
  output logic                    frame_start
);
  localparam int LUT_N = 1 << LUT_AW;
  localparam int PW    = OUT_W + AMP_W + 1;
  localparam int CW1   = CH_W + 1;
  localparam logic [AMP_W-1:0]     AMP_UNITY = AMP_W'(32'd1 << (AMP_W - 1));
  localparam logic [CH_W-1:0]      LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [CW1-1:0]       NUM_CH_L  = CW1'(NUM_CH);
  localparam logic signed [PW-1:0] SAT_MAX   = PW'((32'sd1 <<< (OUT_W - 1)) - 32'sd1);
  localparam logic signed [PW-1:0] SAT_MIN   = PW'(-(32'sd1 <<< (OUT_W - 1)));
  localparam real PI   = 3.14159265358979323846;
  localparam real PEAK = $itor((32'sd1 <<< (OUT_W - 1)) - 32'sd1);

  // Full-wave sine ROM, rounded half away from zero at elaboration
  logic signed [OUT_W-1:0] sine_lut [LUT_N];
  for (genvar i = 0; i < LUT_N; i++) begin : g_lut
    localparam real SV = PEAK * $sin(2.0 * PI * $itor(i) / $itor(LUT_N));
    localparam int  RV = (SV >= 0.0) ? $rtoi(SV + 0.5) : -$rtoi(0.5 - SV);
    assign sine_lut[i] = OUT_W'(RV);
  end

  logic [PHASE_W-1:0] fcw_sh_r [NUM_CH];
  logic [PHASE_W-1:0] fcw_r [NUM_CH];
  logic [PHASE_W-1:0] step_sh_r [NUM_CH];
  logic [PHASE_W-1:0] step_r [NUM_CH];
  logic [AMP_W-1:0]   amp_sh_r [NUM_CH];
  logic [AMP_W-1:0]   amp_r [NUM_CH];
  logic [PHASE_W-1:0] pow_sh_r [NUM_CH];
  logic [PHASE_W-1:0] pow_r [NUM_CH];
  logic [PHASE_W-1:0] sweep_len_sh_r, sweep_len_r, hop_per_sh_r, hop_per_r;
  logic               enable_r, auto_r;
  logic [1:0]         mode_r;

  logic [2:0]      bank_s;
  logic [5:0]      idx_s;
  logic            idx_ok_s;
  logic [CH_W-1:0] wch_s;
  logic            wr_fcw_s, wr_step_s, wr_amp_s, wr_pow_s, wr_slen_s, wr_hop_s, wr_ctrl_s;

  assign bank_s    = addr[8:6];
  assign idx_s     = addr[5:0];
  assign idx_ok_s  = ({1'b0, idx_s} < 7'(NUM_CH));
  assign wch_s     = idx_s[CH_W-1:0];
  assign wr_fcw_s  = wr_en && (bank_s == 3'd0) && idx_ok_s;
  assign wr_step_s = wr_en && (bank_s == 3'd1) && idx_ok_s;
  assign wr_amp_s  = wr_en && (bank_s == 3'd2) && idx_ok_s;
  assign wr_pow_s  = wr_en && (bank_s == 3'd4) && idx_ok_s;
  assign wr_slen_s = wr_en && (addr == 9'h1C0);
  assign wr_hop_s  = wr_en && (addr == 9'h1C1);
  assign wr_ctrl_s = wr_en && (addr == 9'h1FF);

  // Register bank: shadow always written; active via auto_update or sync commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        fcw_sh_r[k] <= '0; fcw_r[k] <= '0; step_sh_r[k] <= '0; step_r[k] <= '0;
        amp_sh_r[k] <= AMP_UNITY; amp_r[k] <= AMP_UNITY; pow_sh_r[k] <= '0; pow_r[k] <= '0;
      end
      sweep_len_sh_r <= '0; sweep_len_r <= '0; hop_per_sh_r <= '0; hop_per_r <= '0;
      enable_r <= 1'b0; auto_r <= 1'b0; mode_r <= 2'b00;
    end else begin
      if (wr_fcw_s)  fcw_sh_r[wch_s]  <= data;
      if (wr_step_s) step_sh_r[wch_s] <= data;
      if (wr_amp_s)  amp_sh_r[wch_s]  <= data[AMP_W-1:0];
      if (wr_pow_s)  pow_sh_r[wch_s]  <= data;
      if (wr_slen_s) sweep_len_sh_r   <= data;
      if (wr_hop_s)  hop_per_sh_r     <= data;
      if (wr_ctrl_s) begin
        enable_r <= data[7];
        auto_r   <= data[6];
        mode_r   <= data[1:0];
      end
      if (sync) begin
        // a write in the commit cycle is merged into what gets committed
        for (int k = 0; k < NUM_CH; k++) begin
          fcw_r[k]  <= (wr_fcw_s  && wch_s == CH_W'(k)) ? data : fcw_sh_r[k];
          step_r[k] <= (wr_step_s && wch_s == CH_W'(k)) ? data : step_sh_r[k];
          amp_r[k]  <= (wr_amp_s  && wch_s == CH_W'(k)) ? data[AMP_W-1:0] : amp_sh_r[k];
          pow_r[k]  <= (wr_pow_s  && wch_s == CH_W'(k)) ? data : pow_sh_r[k];
        end
        sweep_len_r <= wr_slen_s ? data : sweep_len_sh_r;
        hop_per_r   <= wr_hop_s ? data : hop_per_sh_r;
      end else if (auto_r) begin
        if (wr_fcw_s)  fcw_r[wch_s]  <= data;
        if (wr_step_s) step_r[wch_s] <= data;
        if (wr_amp_s)  amp_r[wch_s]  <= data[AMP_W-1:0];
        if (wr_pow_s)  pow_r[wch_s]  <= data;
        if (wr_slen_s) sweep_len_r   <= data;
        if (wr_hop_s)  hop_per_r     <= data;
      end
    end
  end

  logic [PHASE_W-1:0] acc_r [NUM_CH];
  logic [PHASE_W-1:0] off_r [NUM_CH];
  logic [CH_W-1:0]    ch_cnt_r, hop_idx_r;
  logic [PHASE_W-1:0] sweep_cnt_r, hop_cnt_r;

  logic [CW1-1:0]     cfs_sum_s;
  logic [CH_W-1:0]    cfs_ch_s;
  logic [PHASE_W-1:0] eff_fcw_s, phase_s, hop_last_val_s;
  logic               sweep_last_s, hop_last_s, frame_end_s, clear_s;
  logic               unused_phase_bits;

  // Issue-stage combinational: effective FCW, output phase, wrap conditions
  always_comb begin
    cfs_sum_s = {1'b0, ch_cnt_r} + {1'b0, hop_idx_r};
    if (cfs_sum_s >= NUM_CH_L) cfs_ch_s = CH_W'(cfs_sum_s - NUM_CH_L);
    else                       cfs_ch_s = cfs_sum_s[CH_W-1:0];
    case (mode_r)
      2'b00:   eff_fcw_s = fcw_r[ch_cnt_r];
      2'b01:   eff_fcw_s = fcw_r[0];
      2'b10:   eff_fcw_s = fcw_r[ch_cnt_r] + off_r[ch_cnt_r];
      2'b11:   eff_fcw_s = fcw_r[cfs_ch_s];
      default: eff_fcw_s = fcw_r[ch_cnt_r];
    endcase
    phase_s = acc_r[ch_cnt_r] + pow_r[ch_cnt_r];
    sweep_last_s = (sweep_len_r != '0) && (sweep_cnt_r == sweep_len_r - PHASE_W'(1'b1));
    if (hop_per_r == '0) hop_last_val_s = '0;
    else                 hop_last_val_s = hop_per_r - PHASE_W'(1'b1);
    hop_last_s  = (hop_cnt_r == hop_last_val_s);
    frame_end_s = enable_r && (ch_cnt_r == LAST_CH);
    clear_s     = sync || (wr_ctrl_s && data[7] && !enable_r);
  end

  assign unused_phase_bits = ^phase_s[PHASE_W-LUT_AW-1:0];

  // Channel sequencer, accumulators, sweep offsets and frame counters
  always_ff @(posedge clk) begin
    if (reset || clear_s) begin
      for (int k = 0; k < NUM_CH; k++) begin
        acc_r[k] <= '0;
        off_r[k] <= '0;
      end
      ch_cnt_r <= '0; hop_idx_r <= '0; sweep_cnt_r <= '0; hop_cnt_r <= '0;
    end else if (enable_r) begin
      acc_r[ch_cnt_r] <= acc_r[ch_cnt_r] + eff_fcw_s;
      off_r[ch_cnt_r] <= sweep_last_s ? '0 : off_r[ch_cnt_r] + step_r[ch_cnt_r];
      if (frame_end_s) begin
        ch_cnt_r    <= '0;
        sweep_cnt_r <= sweep_last_s ? '0 : sweep_cnt_r + PHASE_W'(1'b1);
        if (hop_last_s) begin
          hop_cnt_r <= '0;
          hop_idx_r <= (hop_idx_r == LAST_CH) ? '0 : hop_idx_r + CH_W'(1'b1);
        end else begin
          hop_cnt_r <= hop_cnt_r + PHASE_W'(1'b1);
        end
      end else begin
        ch_cnt_r <= ch_cnt_r + CH_W'(1'b1);
      end
    end
  end

  logic [LUT_AW-1:0]       p1_addr_r;
  logic [CH_W-1:0]         p1_ch_r, p2_ch_r;
  logic [AMP_W-1:0]        p1_amp_r, p2_amp_r;
  logic                    p1_valid_r, p2_valid_r;
  logic signed [OUT_W-1:0] p2_lut_r, sat_s;
  logic signed [PW-1:0]    prod_s, shift_s;

  // Amplitude scaling with floor shift and saturation
  always_comb begin
    prod_s  = PW'(p2_lut_r) * PW'($signed({1'b0, p2_amp_r}));
    shift_s = prod_s >>> (AMP_W - 1);
    if (shift_s > SAT_MAX)      sat_s = SAT_MAX[OUT_W-1:0];
    else if (shift_s < SAT_MIN) sat_s = SAT_MIN[OUT_W-1:0];
    else                        sat_s = shift_s[OUT_W-1:0];
  end

  // Three-stage output pipeline: phase, LUT, scaled sample; always drains
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_addr_r <= '0; p1_ch_r <= '0; p1_amp_r <= '0; p1_valid_r <= 1'b0;
      p2_lut_r <= '0; p2_ch_r <= '0; p2_amp_r <= '0; p2_valid_r <= 1'b0;
      sine_out <= '0; current_channel <= '0; channel_valid <= 1'b0; frame_start <= 1'b0;
    end else begin
      p1_addr_r       <= phase_s[PHASE_W-1 -: LUT_AW];
      p1_ch_r         <= ch_cnt_r;
      p1_amp_r        <= amp_r[ch_cnt_r];
      p1_valid_r      <= enable_r;
      p2_lut_r        <= sine_lut[p1_addr_r];
      p2_ch_r         <= p1_ch_r;
      p2_amp_r        <= p1_amp_r;
      p2_valid_r      <= p1_valid_r;
      sine_out        <= p2_valid_r ? sat_s : '0;
      current_channel <= p2_valid_r ? p2_ch_r : {CH_W{1'b0}};
      channel_valid   <= p2_valid_r;
      frame_start     <= p2_valid_r && (p2_ch_r == {CH_W{1'b0}});
    end
  end
endmodule

// File: tb/tb_mc_dds_engine.sv
// Self-checking bench for mc_dds_engine: directed steps plus randomized register traffic,
// every output cycle compared against a frame-level behavioural model.
module tb_mc_dds_engine;
  localparam int NCH  = 32;
  localparam int MASK = 24'hFFFFFF;

  logic               clk = 1'b0;
  logic               reset = 1'b1, wr_en = 1'b0, sync = 1'b0;
  logic [8:0]         addr = 9'd0;
  logic [23:0]        data = 24'd0;
  logic signed [15:0] sine_out;
  logic [4:0]         current_channel;
  logic               channel_valid, frame_start;

  mc_dds_engine dut (
    .clk(clk), .reset(reset), .addr(addr), .data(data), .wr_en(wr_en), .sync(sync),
    .sine_out(sine_out), .current_channel(current_channel),
    .channel_valid(channel_valid), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit strict_idle = 1'b0;

  typedef struct { bit v; int ch; int s; bit f; } exp_t;
  exp_t q[$];

  int lut_ref [1024];
  int m_fcw_sh [NCH], m_fcw [NCH], m_step_sh [NCH], m_step [NCH];
  int m_amp_sh [NCH], m_amp [NCH], m_pow_sh [NCH], m_pow [NCH];
  int m_acc [NCH], m_off [NCH];
  int m_slen_sh, m_slen, m_hop_sh, m_hop;
  int m_ch, m_scnt, m_hcnt, m_hidx;
  bit m_en, m_au;
  int m_mode;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sample(input int ph, input int amp);
    real r;
    int  v;
    r = $floor($itor(lut_ref[ph / 16384] * amp) / 2048.0);
    v = $rtoi(r);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic void clear_run();
    for (int k = 0; k < NCH; k++) begin
      m_acc[k] = 0;
      m_off[k] = 0;
    end
    m_ch = 0; m_scnt = 0; m_hcnt = 0; m_hidx = 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_fcw_sh[k] = 0; m_fcw[k] = 0; m_step_sh[k] = 0; m_step[k] = 0;
      m_amp_sh[k] = 2048; m_amp[k] = 2048; m_pow_sh[k] = 0; m_pow[k] = 0;
    end
    m_slen_sh = 0; m_slen = 0; m_hop_sh = 0; m_hop = 0;
    m_en = 1'b0; m_au = 1'b0; m_mode = 0;
    clear_run();
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back('{1'b0, 0, 0, 1'b0});
  endfunction

  // One clock of the reference: issue from current state, then apply writes/commit/clears
  function automatic void model_cycle(input bit we, input int a, input int d, input bit sy, input bit rs);
    exp_t e;
    int   k, eff, hp;
    bit   swl, rise;
    if (rs) begin
      model_reset();
      return;
    end
    e = '{1'b0, 0, 0, 1'b0};
    if (m_en) begin
      k = m_ch;
      e = '{1'b1, k, sample((m_acc[k] + m_pow[k]) & MASK, m_amp[k]), k == 0};
      case (m_mode)
        1:       eff = m_fcw[0];
        2:       eff = (m_fcw[k] + m_off[k]) & MASK;
        3:       eff = m_fcw[(k + m_hidx) % NCH];
        default: eff = m_fcw[k];
      endcase
      swl = (m_slen != 0) && (m_scnt == m_slen - 1);
      m_acc[k] = (m_acc[k] + eff) & MASK;
      m_off[k] = swl ? 0 : ((m_off[k] + m_step[k]) & MASK);
      if (k == NCH - 1) begin
        m_ch = 0;
        m_scnt = swl ? 0 : ((m_scnt + 1) & MASK);
        hp = (m_hop == 0) ? 1 : m_hop;
        if (m_hcnt == hp - 1) begin
          m_hcnt = 0;
          m_hidx = (m_hidx + 1) % NCH;
        end else begin
          m_hcnt = (m_hcnt + 1) & MASK;
        end
      end else begin
        m_ch = k + 1;
      end
    end
    rise = we && (a == 511) && d[7] && !m_en;
    if (we) begin
      if (a < NCH) begin m_fcw_sh[a] = d; if (m_au) m_fcw[a] = d; end
      else if (a >= 64 && a < 64 + NCH) begin m_step_sh[a-64] = d; if (m_au) m_step[a-64] = d; end
      else if (a >= 128 && a < 128 + NCH) begin m_amp_sh[a-128] = d % 4096; if (m_au) m_amp[a-128] = d % 4096; end
      else if (a >= 256 && a < 256 + NCH) begin m_pow_sh[a-256] = d; if (m_au) m_pow[a-256] = d; end
      else if (a == 448) begin m_slen_sh = d; if (m_au) m_slen = d; end
      else if (a == 449) begin m_hop_sh = d; if (m_au) m_hop = d; end
      else if (a == 511) begin m_en = d[7]; m_au = d[6]; m_mode = d % 4; end
    end
    if (sy) begin
      m_fcw = m_fcw_sh; m_step = m_step_sh; m_amp = m_amp_sh; m_pow = m_pow_sh;
      m_slen = m_slen_sh; m_hop = m_hop_sh;
    end
    if (sy || rise) clear_run();
    q.push_back(e);
  endfunction

  task automatic step(input bit we, input int a, input int d, input bit sy, input bit rs);
    exp_t e;
    reset = rs; wr_en = we; addr = 9'(a); data = 24'(d); sync = sy;
    model_cycle(we, a, d, sy, rs);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    check("valid", channel_valid, e.v);
    check("frame_start", frame_start, e.f);
    if (e.v) begin
      check("channel", current_channel, e.ch);
      check("sine", sine_out, e.s);
    end else if (strict_idle) begin
      check("idle_sine", sine_out, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic wr(input int a, input int d);
    step(1'b1, a, d, 1'b0, 1'b0);
  endtask

  initial begin
    int fs;
    for (int i = 0; i < 1024; i++) begin
      real x;
      x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * $itor(i) / 1024.0);
      lut_ref[i] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    end
    @(negedge clk);

    // reset then idle
    strict_idle = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 1'b0, 1'b1);
    idle(20);
    check("idle_valid", channel_valid, 0);
    check("idle_frame", frame_start, 0);
    check("idle_out", sine_out, 0);
    strict_idle = 1'b0;

    // PCW with quarter-wave phase offsets
    wr(511, 32'hC1);
    wr(0, 6711);
    wr(257, 4194304);
    wr(258, 8388608);
    wr(259, 12582912);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    idle(3);
    check("pcw_ch0", sine_out, 0);
    check("pcw_fs0", frame_start, 1);
    idle(1);
    check("pcw_ch1", sine_out, 32767);
    check("pcw_tag1", current_channel, 1);
    idle(1);
    check("pcw_ch2", sine_out, 0);
    idle(1);
    check("pcw_ch3", sine_out, -32767);
    fs = 0;
    for (int i = 0; i < 64; i++) begin
      idle(1);
      fs += frame_start;
    end
    check("frame_period", fs, 2);

    // shadow copy: FCW change invisible until sync
    wr(511, 32'h80);
    wr(0, 5000);
    idle(70);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    idle(70);

    // amplitude scaling and saturation, write merged into sync
    wr(511, 32'hC0);
    wr(0, 0);
    wr(256, 4194304);
    wr(128, 1024);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    idle(3);
    check("amp_half", sine_out, 16383);
    step(1'b1, 128, 4095, 1'b1, 1'b0);
    idle(3);
    check("amp_sat_pos", sine_out, 32767);
    step(1'b1, 256, 12582912, 1'b1, 1'b0);
    idle(3);
    check("amp_sat_neg", sine_out, -32768);
    idle(40);

    // LFM sweep
    wr(511, 32'hC2);
    wr(128, 2048);
    wr(256, 0);
    wr(64, 1000);
    wr(448, 4);
    wr(1, 300000);
    wr(65, 24'hFF3CB0);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    idle(300);

    // CFS hopping
    wr(511, 32'hC3);
    for (int k = 0; k < NCH; k++) wr(k, 4000 + 1000 * k + (k << 16));
    wr(449, 2);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    idle(300);
    step(1'b1, 3, 77777, 1'b1, 1'b0);
    idle(100);
    wr(449, 0);
    idle(150);

    // disable drains and holds, re-enable restarts
    wr(511, 32'h43);
    idle(10);
    check("disabled_valid", channel_valid, 0);
    wr(511, 32'hC0);
    idle(40);

    // randomized register traffic, commits, mode changes and a mid-stream reset
    for (int i = 0; i < 4000; i++) begin
      int  r, a, d;
      bit  we, sy, rs;
      r = $urandom_range(0, 99);
      we = 1'b0; a = 0;
      d = $urandom() & MASK;
      sy = ($urandom_range(0, 49) == 0);
      rs = (i == 2000);
      if (r < 30) begin
        we = 1'b1;
        case ($urandom_range(0, 7))
          0, 1: a = $urandom_range(0, 63);
          2: a = 64 + $urandom_range(0, 63);
          3: a = 128 + $urandom_range(0, 40);
          4: a = 256 + $urandom_range(0, 63);
          5: begin a = 448 + $urandom_range(0, 1); d = $urandom_range(0, 6); end
          6: begin
            a = 511;
            d = (($urandom_range(0, 9) != 0) ? 128 : 0) + 64 * $urandom_range(0, 1) + $urandom_range(0, 3);
          end
          default: a = $urandom_range(0, 511);
        endcase
      end
      step(we, a, d, sy, rs);
      if (rs) check("reset_valid", channel_valid, 0);
      if (i == 2001) wr(511, 32'hC0 + $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
